// File: rtl/can_rx_destuff_if.sv
// Bus between the bit sampler / frame decoder and the receive destuffer.
interface can_rx_destuff_if;
  logic       destuff_en;
  logic       sample_valid;
  logic       rx_bit;
  logic       bit_out;
  logic       bit_out_valid;
  logic       stuff_drop;
  logic       stuff_error;
  logic [7:0] data_byte;
  logic       byte_valid;

  // Driver side: upstream sampler plus frame-decoder enable
  modport master (
    output destuff_en, sample_valid, rx_bit,
    input  bit_out, bit_out_valid, stuff_drop, stuff_error, data_byte, byte_valid
  );

  // Destuffer side
  modport slave (
    input  destuff_en, sample_valid, rx_bit,
    output bit_out, bit_out_valid, stuff_drop, stuff_error, data_byte, byte_valid
  );
endinterface

// File: rtl/can_rx_destuff.sv
// CAN receive bit destuffer and MSB-first byte assembler.
// All state updates on the falling edge of clock.
module can_rx_destuff #(
  parameter int unsigned STUFF_LEN = 5
) (
  input logic          clock,
  input logic          reset_n,
  can_rx_destuff_if.slave bus
);

  localparam logic [2:0] LP_LEN = 3'(STUFF_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_RUN,
    S_EXPECT,
    S_ERROR
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_last_bit, w_last_bit;
  logic [2:0] r_run_cnt, w_run_cnt;
  logic [2:0] r_bit_idx, w_bit_idx;
  logic [7:0] r_shift, w_shift;
  logic [7:0] r_data_byte, w_data_byte;
  logic       r_bit_out, w_bit_out;
  logic       r_bit_vld, w_bit_vld;
  logic       r_drop, w_drop;
  logic       r_err, w_err;
  logic       r_byte_vld, w_byte_vld;
  logic       w_emit;
  logic       w_emit_bit;

  // State and output registers
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_last_bit  <= 1'b0;
      r_run_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data_byte <= '0;
      r_bit_out   <= 1'b0;
      r_bit_vld   <= 1'b0;
      r_drop      <= 1'b0;
      r_err       <= 1'b0;
      r_byte_vld  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_bit  <= w_last_bit;
      r_run_cnt   <= w_run_cnt;
      r_bit_idx   <= w_bit_idx;
      r_shift     <= w_shift;
      r_data_byte <= w_data_byte;
      r_bit_out   <= w_bit_out;
      r_bit_vld   <= w_bit_vld;
      r_drop      <= w_drop;
      r_err       <= w_err;
      r_byte_vld  <= w_byte_vld;
    end
  end

  // Next-state, run tracking and byte assembly
  always_comb begin
    w_state_nxt = r_state;
    w_last_bit  = r_last_bit;
    w_run_cnt   = r_run_cnt;
    w_bit_idx   = r_bit_idx;
    w_shift     = r_shift;
    w_data_byte = r_data_byte;
    w_bit_out   = r_bit_out;
    w_bit_vld   = 1'b0;
    w_drop      = 1'b0;
    w_err       = r_err;
    w_byte_vld  = 1'b0;
    w_emit      = 1'b0;
    w_emit_bit  = 1'b0;

    if (!bus.destuff_en) begin
      // Disable wins over any sample; data_byte is kept
      w_state_nxt = S_IDLE;
      w_last_bit  = 1'b0;
      w_run_cnt   = '0;
      w_bit_idx   = '0;
      w_shift     = '0;
      w_err       = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_FIRST;
        S_FIRST: begin
          if (bus.sample_valid) begin
            w_emit      = 1'b1;
            w_emit_bit  = bus.rx_bit;
            w_last_bit  = bus.rx_bit;
            w_run_cnt   = 3'd1;
            w_state_nxt = (LP_LEN == 3'd1) ? S_EXPECT : S_RUN;
          end
        end
        S_RUN: begin
          if (bus.sample_valid) begin
            w_emit     = 1'b1;
            w_emit_bit = bus.rx_bit;
            if (bus.rx_bit == r_last_bit) begin
              w_run_cnt = r_run_cnt + 3'd1;
            end else begin
              w_run_cnt  = 3'd1;
              w_last_bit = bus.rx_bit;
            end
            w_state_nxt = (w_run_cnt == LP_LEN) ? S_EXPECT : S_RUN;
          end
        end
        S_EXPECT: begin
          if (bus.sample_valid) begin
            if (bus.rx_bit != r_last_bit) begin
              // Stuff bit opens the next run
              w_drop      = 1'b1;
              w_last_bit  = bus.rx_bit;
              w_run_cnt   = 3'd1;
              w_state_nxt = (LP_LEN == 3'd1) ? S_EXPECT : S_RUN;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = S_ERROR;
            end
          end
        end
        S_ERROR: w_state_nxt = S_ERROR;
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_emit) begin
        w_bit_out = w_emit_bit;
        w_bit_vld = 1'b1;
        w_shift   = {r_shift[6:0], w_emit_bit};
        w_bit_idx = r_bit_idx + 3'd1;
        if (r_bit_idx == 3'd7) begin
          w_data_byte = {r_shift[6:0], w_emit_bit};
          w_byte_vld  = 1'b1;
        end
      end
    end
  end

  assign bus.bit_out       = r_bit_out;
  assign bus.bit_out_valid = r_bit_vld;
  assign bus.stuff_drop    = r_drop;
  assign bus.stuff_error   = r_err;
  assign bus.data_byte     = r_data_byte;
  assign bus.byte_valid    = r_byte_vld;

endmodule

// File: tb/tb_can_rx_destuff.sv
// Directed bench for can_rx_destuff (STUFF_LEN = 5).
module tb_can_rx_destuff;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   n_drops;

  can_rx_destuff_if bus ();

  can_rx_destuff #(.STUFF_LEN(5)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One sample per call: drive at rising edge, DUT captures at falling edge, check 1 ns later
  task automatic send(input logic b, input logic ev, input logic eb, input logic ed,
                      input logic ee, input logic ebv, input logic [7:0] edata);
    @(posedge clock);
    bus.sample_valid = 1'b1;
    bus.rx_bit       = b;
    @(negedge clock);
    #1;
    check("bit_out_valid", 32'(bus.bit_out_valid), 32'(ev));
    if (ev) check("bit_out", 32'(bus.bit_out), 32'(eb));
    check("stuff_drop", 32'(bus.stuff_drop), 32'(ed));
    check("stuff_error", 32'(bus.stuff_error), 32'(ee));
    check("byte_valid", 32'(bus.byte_valid), 32'(ebv));
    if (ebv) check("data_byte", 32'(bus.data_byte), 32'(edata));
    if (bus.stuff_drop) n_drops++;
    bus.sample_valid = 1'b0;
  endtask

  task automatic enable();
    @(posedge clock);
    bus.destuff_en = 1'b1;
    @(negedge clock);
    #1;
    n_drops = 0;
  endtask

  task automatic disable_chk();
    @(posedge clock);
    bus.destuff_en = 1'b0;
    @(negedge clock);
    #1;
    check("err_clear_on_disable", 32'(bus.stuff_error), 32'd0);
  endtask

  task automatic idle_chk(input string tag);
    @(posedge clock);
    bus.sample_valid = 1'b0;
    @(negedge clock);
    #1;
    check(tag, {29'd0, bus.bit_out_valid, bus.stuff_drop, bus.byte_valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {22'd0, bus.bit_out, bus.bit_out_valid, bus.stuff_drop,
                bus.stuff_error, bus.byte_valid, bus.data_byte[4:0]}, 32'd0);
    check({tag, "_byte"}, 32'(bus.data_byte), 32'd0);
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    n_drops          = 0;
    reset_n          = 1'b0;
    bus.destuff_en   = 1'b0;
    bus.sample_valid = 1'b0;
    bus.rx_bit       = 1'b0;
    #12;
    check_all_zero("reset_state");
    @(posedge clock);
    reset_n = 1'b1;

    // Sample while idle is ignored
    send(1'b1, 0, 0, 0, 0, 0, 8'h00);

    // 1,1,1,1,1,0(stuff),1
    enable();
    for (int unsigned i = 0; i < 5; i++) send(1'b1, 1, 1, 0, 0, 0, 8'h00);
    send(1'b0, 0, 0, 1, 0, 0, 8'h00);
    send(1'b1, 1, 1, 0, 0, 0, 8'h00);
    idle_chk("pulse_width_t1");
    disable_chk();

    // six 0s -> error, then ignored samples
    enable();
    for (int unsigned i = 0; i < 5; i++) send(1'b0, 1, 0, 0, 0, 0, 8'h00);
    send(1'b0, 0, 0, 0, 1, 0, 8'h00);
    send(1'b1, 0, 0, 0, 1, 0, 8'h00);
    send(1'b0, 0, 0, 0, 1, 0, 8'h00);
    send(1'b1, 0, 0, 0, 1, 0, 8'h00);
    disable_chk();

    // alternating byte 0xAA, back-to-back samples
    enable();
    for (int unsigned i = 0; i < 8; i++) begin
      logic bb;
      bb = (i % 2 == 0);
      send(bb, 1, bb, 0, 0, (i == 7), 8'hAA);
    end
    check("drops_aa", n_drops, 0);
    disable_chk();

    // 1x5, 0 stuff, 0x4, 1 stuff, 0 -> byte 0xF8 on 8th output
    enable();
    for (int unsigned i = 0; i < 5; i++) send(1'b1, 1, 1, 0, 0, 0, 8'h00);
    send(1'b0, 0, 0, 1, 0, 0, 8'h00);
    send(1'b0, 1, 0, 0, 0, 0, 8'h00);
    send(1'b0, 1, 0, 0, 0, 0, 8'h00);
    send(1'b0, 1, 0, 0, 0, 1, 8'hF8);
    send(1'b0, 1, 0, 0, 0, 0, 8'h00);
    send(1'b1, 0, 0, 1, 0, 0, 8'h00);
    send(1'b0, 1, 0, 0, 0, 0, 8'h00);
    check("drops_two_stuff", n_drops, 2);
    disable_chk();

    // 0x3C then 0xFF with one stuff bit inside 0xFF
    enable();
    begin
      logic [7:0] v;
      v = 8'h3C;
      for (int unsigned i = 0; i < 8; i++) send(v[7-i], 1, v[7-i], 0, 0, (i == 7), 8'h3C);
    end
    for (int unsigned i = 0; i < 5; i++) send(1'b1, 1, 1, 0, 0, 0, 8'h00);
    send(1'b0, 0, 0, 1, 0, 0, 8'h00);
    send(1'b1, 1, 1, 0, 0, 0, 8'h00);
    send(1'b1, 1, 1, 0, 0, 0, 8'h00);
    send(1'b1, 1, 1, 0, 0, 1, 8'hFF);
    check("drops_3c_ff", n_drops, 1);
    idle_chk("pulse_width_t5");

    // Async reset mid-byte
    disable_chk();
    enable();
    for (int unsigned i = 0; i < 3; i++) send(1'b1, 1, 1, 0, 0, 0, 8'h00);
    @(posedge clock);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    disable_chk();

    // Disable after 3 bits, re-enable: fresh byte 0xF5, run restarts
    enable();
    for (int unsigned i = 0; i < 3; i++) send(1'b1, 1, 1, 0, 0, 0, 8'h00);
    disable_chk();
    enable();
    begin
      logic [7:0] v;
      v = 8'hF5;
      for (int unsigned i = 0; i < 8; i++) send(v[7-i], 1, v[7-i], 0, 0, (i == 7), 8'hF5);
    end
    check("drops_restart", n_drops, 0);
    disable_chk();
    check("byte_kept_after_disable", 32'(bus.data_byte), 32'hF5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
